// File: rtl/cmos_axis_frame_gate.sv
// rtl/cmos_axis_frame_gate.sv - frame-aligned AXI4-Stream video gate with frame geometry measurement
//
// Ports:
//   aclk, aresetn           clock, asynchronous active-low reset
//   enable                  gate request, honoured only at start-of-frame beats
//   s_axis_video_*          upstream pixel stream (tuser = SOF, tlast = EOL)
//   m_axis_video_*          gated pixel stream, one register slice, 1-cycle latency
//   frame_width             pixels in the first line of the last completed frame
//   frame_height            EOL count of the last completed frame
//   frame_count             completed-frame counter (wraps)
//   frame_done              one-cycle pulse when a frame completes
//   line_err                one-cycle pulse on a line-length mismatch or a missing EOL

module cmos_axis_frame_gate #(
    parameter int HCNT_W = 12,
    parameter int VCNT_W = 12
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              enable,
    input  logic [31:0]       s_axis_video_tdata,
    input  logic              s_axis_video_tvalid,
    output logic              s_axis_video_tready,
    input  logic              s_axis_video_tuser,
    input  logic              s_axis_video_tlast,
    output logic [31:0]       m_axis_video_tdata,
    output logic              m_axis_video_tvalid,
    input  logic              m_axis_video_tready,
    output logic              m_axis_video_tuser,
    output logic              m_axis_video_tlast,
    output logic [HCNT_W-1:0] frame_width,
    output logic [VCNT_W-1:0] frame_height,
    output logic [15:0]       frame_count,
    output logic              frame_done,
    output logic              line_err
);

    typedef enum logic [0:0] {
        WAIT_SOF = 1'b0,
        PASS     = 1'b1
    } state_t;

    localparam logic [HCNT_W-1:0] PCNT_MAX = '1;
    localparam logic [VCNT_W-1:0] LCNT_MAX = '1;

    state_t              state;
    state_t              state_nxt;
    logic                run;
    logic                accept;
    logic                load;
    logic                sof_report;
    logic [HCNT_W-1:0]   pcnt;
    logic [HCNT_W-1:0]   line_len;
    logic [HCNT_W-1:0]   work_w;
    logic [VCNT_W-1:0]   lcnt;
    logic [VCNT_W-1:0]   lcnt_inc;
    logic                first_line;

    // run is low only while reset is held, so tready drops during reset and
    // comes up on the first edge after release. The output slice also holds
    // off input while a beat is stalled in WAIT_SOF (draining after the gate
    // closed), so an enabled SOF can never overwrite an undelivered beat.
    assign s_axis_video_tready = run & (~m_axis_video_tvalid | m_axis_video_tready);
    assign accept              = s_axis_video_tvalid & s_axis_video_tready;

    // Length of the line including the current beat, saturating.
    assign line_len = (pcnt == PCNT_MAX) ? pcnt : pcnt + HCNT_W'(1);
    assign lcnt_inc = (lcnt == LCNT_MAX) ? lcnt : lcnt + VCNT_W'(1);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= WAIT_SOF;
            run   <= 1'b0;
        end else begin
            state <= state_nxt;
            run   <= 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        load       = 1'b0;
        sof_report = 1'b0;
        case (state)
            WAIT_SOF: begin
                if (accept && s_axis_video_tuser && enable) begin
                    load      = 1'b1;
                    state_nxt = PASS;
                end
            end
            PASS: begin
                if (accept) begin
                    if (s_axis_video_tuser) begin
                        sof_report = 1'b1;
                        if (enable) begin
                            load = 1'b1;
                        end else begin
                            state_nxt = WAIT_SOF;
                        end
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            default: state_nxt = WAIT_SOF;
        endcase
    end

    // Output register slice.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_video_tvalid <= 1'b0;
            m_axis_video_tdata  <= '0;
            m_axis_video_tuser  <= 1'b0;
            m_axis_video_tlast  <= 1'b0;
        end else if (load) begin
            m_axis_video_tvalid <= 1'b1;
            m_axis_video_tdata  <= s_axis_video_tdata;
            m_axis_video_tuser  <= s_axis_video_tuser;
            m_axis_video_tlast  <= s_axis_video_tlast;
        end else if (m_axis_video_tready) begin
            m_axis_video_tvalid <= 1'b0;
        end
    end

    // Geometry counters and frame statistics.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pcnt         <= '0;
            lcnt         <= '0;
            work_w       <= '0;
            first_line   <= 1'b1;
            frame_width  <= '0;
            frame_height <= '0;
            frame_count  <= '0;
            frame_done   <= 1'b0;
            line_err     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            line_err   <= 1'b0;

            if (sof_report) begin
                frame_width  <= work_w;
                frame_height <= lcnt;
                frame_count  <= frame_count + 16'd1;
                frame_done   <= 1'b1;
                // Non-zero pixel count at SOF means the last line had no EOL.
                if (pcnt != '0) begin
                    line_err <= 1'b1;
                end
            end

            if (accept && s_axis_video_tuser) begin
                // Any SOF restarts the geometry; if forwarded it is pixel 0 of line 0.
                pcnt       <= '0;
                lcnt       <= '0;
                first_line <= 1'b1;
                if (load && s_axis_video_tlast) begin
                    work_w     <= HCNT_W'(1);
                    first_line <= 1'b0;
                    lcnt       <= VCNT_W'(1);
                end else if (load) begin
                    pcnt <= HCNT_W'(1);
                end
            end else if (load) begin
                if (s_axis_video_tlast) begin
                    pcnt <= '0;
                    lcnt <= lcnt_inc;
                    if (first_line) begin
                        work_w     <= line_len;
                        first_line <= 1'b0;
                    end else if (line_len != work_w) begin
                        line_err <= 1'b1;
                    end
                end else begin
                    pcnt <= line_len;
                end
            end
        end
    end

endmodule

// File: tb/tb_cmos_axis_frame_gate.sv
// tb/tb_cmos_axis_frame_gate.sv - scoreboard bench for cmos_axis_frame_gate

module tb_cmos_axis_frame_gate;

    localparam int HW = 12;
    localparam int VW = 12;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          enable = 1'b0;
    logic [31:0]   s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          s_tuser = 1'b0;
    logic          s_tlast = 1'b0;
    logic [31:0]   m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic          m_tuser;
    logic          m_tlast;
    logic [HW-1:0] frame_width;
    logic [VW-1:0] frame_height;
    logic [15:0]   frame_count;
    logic          frame_done;
    logic          line_err;

    cmos_axis_frame_gate #(.HCNT_W(HW), .VCNT_W(VW)) dut (
        .aclk                (aclk),
        .aresetn             (aresetn),
        .enable              (enable),
        .s_axis_video_tdata  (s_tdata),
        .s_axis_video_tvalid (s_tvalid),
        .s_axis_video_tready (s_tready),
        .s_axis_video_tuser  (s_tuser),
        .s_axis_video_tlast  (s_tlast),
        .m_axis_video_tdata  (m_tdata),
        .m_axis_video_tvalid (m_tvalid),
        .m_axis_video_tready (m_tready),
        .m_axis_video_tuser  (m_tuser),
        .m_axis_video_tlast  (m_tlast),
        .frame_width         (frame_width),
        .frame_height        (frame_height),
        .frame_count         (frame_count),
        .frame_done          (frame_done),
        .line_err            (line_err)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] data;
        logic        user;
        logic        last;
        int          cyc;
    } beat_t;

    typedef struct {
        int   w;
        int   h;
        int   cnt;
        logic err;
    } stat_t;

    beat_t exp_q[$];
    stat_t stat_q[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    bit    rand_rdy = 1'b0;

    // Reference model: frame-level bookkeeping of what the gate should do.
    bit    md_pass = 1'b0;
    int    md_first_w = -1;
    int    md_lines = 0;
    int    md_pix = 0;
    int    md_fcnt = 0;
    int    exp_err = 0;
    int    obs_err = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void model_beat(logic [31:0] d, logic u, logic l, logic en);
        stat_t st;
        if (u) begin
            if (md_pass) begin
                md_fcnt++;
                st.w   = md_first_w;
                st.h   = md_lines;
                st.cnt = md_fcnt & 32'hffff;
                st.err = (md_pix != 0);
                stat_q.push_back(st);
                if (md_pix != 0) exp_err++;
            end
            md_pass    = en;
            md_first_w = -1;
            md_lines   = 0;
            md_pix     = 0;
        end
        if (!md_pass) return;
        exp_q.push_back('{d, u, l, cyc});
        md_pix++;
        if (l) begin
            if (md_first_w < 0) md_first_w = md_pix;
            else if (md_pix != md_first_w) exp_err++;
            md_lines++;
            md_pix = 0;
        end
    endfunction

    always @(posedge aclk) cyc <= cyc + 1;

    always @(posedge aclk) begin
        #1;
        m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor
    bit          prev_stall = 1'b0;
    logic [34:0] prev_out = '0;
    int          present_cyc = 0;

    always @(negedge aclk) begin
        beat_t e;
        stat_t st;
        if (!aresetn) begin
            prev_stall = 1'b0;
        end else begin
            if (frame_done) begin
                if (stat_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_done: got unexpected pulse, required none (cycle %0d)", cyc);
                end else begin
                    st = stat_q.pop_front();
                    check("frame_width", frame_width, st.w);
                    check("frame_height", frame_height, st.h);
                    check("frame_count", frame_count, st.cnt);
                    check("line_err_at_sof", line_err, st.err);
                end
            end
            if (line_err) obs_err++;
            if (prev_stall)
                check("stall_hold", {m_tvalid, m_tuser, m_tlast, m_tdata}, prev_out);
            if (m_tvalid && !prev_stall) present_cyc = cyc;
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_beat: got unexpected data %0h, required no beat (cycle %0d)", m_tdata, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", m_tdata, e.data);
                    check("out_user", m_tuser, e.user);
                    check("out_last", m_tlast, e.last);
                    check("out_latency_cycle", present_cyc, e.cyc);
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_out   = {m_tvalid, m_tuser, m_tlast, m_tdata};
        end
    end

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic u, input logic l);
        int n;
        bit ok;
        s_tdata  = d;
        s_tuser  = u;
        s_tlast  = l;
        s_tvalid = 1'b1;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 1000) begin
            @(negedge aclk);
            if (s_tready) ok = 1'b1;
            else n++;
        end
        @(posedge aclk);
        #1;
        if (ok) begin
            model_beat(d, u, l, enable);
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no tready in %0d cycles, required handshake", n);
        end
        s_tvalid = 1'b0;
    endtask

    task automatic send_line(input int len, input bit sof, input bit eol);
        for (int i = 0; i < len; i++)
            send($urandom, sof && (i == 0), eol && (i == len - 1));
    endtask

    task automatic send_frame(input int nlines, input int w);
        for (int ln = 0; ln < nlines; ln++)
            send_line(w, ln == 0, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_s_tready", s_tready, 0);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_frame_width", frame_width, 0);
        check("rst_frame_height", frame_height, 0);
        check("rst_pulses", {frame_done, line_err}, 0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        check("post_rst_s_tready", s_tready, 1);

        // Junk before SOF, then a clean 4x3 frame closed by the next SOF
        enable = 1'b1;
        for (int i = 0; i < 3; i++) send($urandom, 1'b0, 1'b0);
        send_frame(3, 4);

        // Next frame: widths 4,3,4 -> one length error
        send($urandom, 1'b1, 1'b0);
        idle(2);
        check("a_frame_count", frame_count, 1);
        check("a_frame_width", frame_width, 4);
        check("a_frame_height", frame_height, 3);
        send_line(3, 1'b0, 1'b1);
        send_line(3, 1'b0, 1'b1);
        send_line(4, 1'b0, 1'b1);

        // 4x2 frame plus two pixels without EOL, then SOF
        send_frame(2, 4);
        check("b_frame_width", frame_width, 4);
        send_line(2, 1'b0, 1'b0);
        send($urandom, 1'b1, 1'b0);
        idle(2);
        check("c_frame_count", frame_count, 3);
        check("c_frame_height", frame_height, 2);
        send_line(3, 1'b0, 1'b1);
        send_line(4, 1'b0, 1'b1);

        // Random backpressure over two 640x2 frames
        rand_rdy = 1'b1;
        send_frame(2, 640);
        send_frame(2, 640);

        // Enable dropped mid-frame
        send_line(4, 1'b1, 1'b1);
        enable = 1'b0;
        send_line(4, 1'b0, 1'b1);
        send_frame(2, 4);
        enable = 1'b1;
        send_frame(2, 4);
        send_frame(1, 4);

        // Reset mid-line with a beat held in the output register
        rand_rdy = 1'b0;
        idle(3);
        send_line(2, 1'b0, 1'b0);
        #2;
        check("pre_rst_m_tvalid", m_tvalid, 1);
        aresetn = 1'b0;
        #1;
        check("mid_rst_m_tvalid", m_tvalid, 0);
        check("mid_rst_s_tready", s_tready, 0);
        check("mid_rst_frame_count", frame_count, 0);
        check("mid_rst_geometry", {frame_width, frame_height}, 0);
        exp_q.delete();
        stat_q.delete();
        md_pass    = 1'b0;
        md_first_w = -1;
        md_lines   = 0;
        md_pix     = 0;
        md_fcnt    = 0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        for (int i = 0; i < 3; i++) send($urandom, 1'b0, 1'b1);
        send_frame(1, 4);
        send($urandom, 1'b1, 1'b0);
        idle(2);
        check("f_frame_count", frame_count, 1);
        check("f_frame_width", frame_width, 4);
        check("f_frame_height", frame_height, 1);

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge aclk);
            n++;
        end
        idle(2);
        check("drain_exp_q", exp_q.size(), 0);
        check("drain_stat_q", stat_q.size(), 0);
        check("line_err_total", obs_err, exp_err);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
